wave_gen_multi: RTL and testbench
=================================

# wave_gen_multi

Parametrised multi-channel waveform generator that succeeds the single-channel wave core inside `tt_um_waves`. Each channel has its own phase accumulator, frequency tuning word, mode and duty setting, all programmed through a simple register-write port. Every channel produces its own registered sample, and a registered sum of all channels drives the mixer/DAC path.

## Interface
- `CHANNELS`, 2: number of independent channels; must be at least 2.
- `ACC_W`, 16: phase accumulator and tuning-word width.
- `DATA_W`, 8: sample width; must be at most 16 and at most `ACC_W`.
- `CH_W`, `$clog2(CHANNELS)`: width of the channel select.

- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: global run enable; when low, all state holds.
- `wr_en` input 1: register write strobe, one write per cycle.
- `wr_ch` input `CH_W`: target channel; writes to an out-of-range channel are ignored.
- `wr_sel` input 2: register select.
  - 0 = FTW.
  - 1 = CTRL, with bits [1:0] = mode and bit 2 = channel enable.
  - 2 = DUTY, taken from `wr_data[DATA_W-1:0]`.
  - 3 = phase reset; data is ignored.
- `wr_data` input `ACC_W`: write data.
- `wave_out` output `CHANNELS*DATA_W`: registered samples; channel i occupies `[i*DATA_W +: DATA_W]`.
- `wrap` output `CHANNELS`: one-cycle pulse per channel on accumulator carry-out.
- `mix_out` output `DATA_W+CH_W`: registered unsigned sum of all `wave_out` lanes.

## Operation
**Reset values.**
- acc = 0, FTW = 0, mode = 0, channel enable = 0.
- DUTY = 2^(DATA_W-1).
- LFSR = 16'hACE1.
- `wave_out`, `wrap` and `mix_out` = 0.

**Accumulator.**
- Per channel, when `ena`=1 and the channel is enabled: acc <= (acc + FTW) mod 2^ACC_W.
- The carry-out of that addition sets `wrap[i]` for the next cycle.

**Phase.** p = acc[ACC_W-1 -: DATA_W], taken from the pre-update acc.

**Modes.**
- 0, square: the sample is all-ones when p < DUTY, otherwise 0.
- 1, saw: the sample is p.
- 2, triangle: t = {p[DATA_W-2:0], 1'b0}; the sample is t when p[DATA_W-1]=0, otherwise ~t.
- 3, noise: the sample is lfsr[DATA_W-1:0].
  - The LFSR advances on each `wrap` event of its own channel.
  - Step: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.

**Disabled channel.** acc, LFSR and `wrap` hold or stay low, and the `wave_out` lane registers 0.

**`ena`=0.**
- acc, LFSR, `wave_out` and `mix_out` hold, and `wrap` is 0.
- Register writes are still accepted.

**Phase reset.** Sets acc <= 0 at that edge; this overrides the increment, and `wrap` stays low that cycle. The LFSR is not reseeded.

## Timing
- A write at edge k updates the register at k. An addition occurring at the same edge k uses the old FTW; the new FTW is first used at edge k+1.
- `wave_out` at cycle n+1 is the function of acc and the settings at cycle n: one cycle of latency from acc.
- `wrap[i]` rises in the cycle after the edge that produced the carry and lasts exactly one cycle.
- `mix_out` lags `wave_out` by one cycle, so it is two cycles behind acc.
- Mid-operation reset clears all state immediately. The first valid sample appears one cycle after release, once the channel has been re-enabled by a write.
- A mode change takes effect in the `wave_out` registered at the edge after the write.

## Configuration
- `WAVE_NOISE_EN` defined: mode 3 behaves as described, with one 16-bit LFSR per channel.
- `WAVE_NOISE_EN` undefined:
  - No LFSR is instantiated.
  - Mode 3 outputs 0.
  - `wrap` behaviour is unchanged.

## Test plan
All scenarios use the defaults CHANNELS=2, ACC_W=16, DATA_W=8.
- Reset: assert `rst_n`=0 mid-run → `wave_out`=0, `mix_out`=0, `wrap`=0 asynchronously; after release with no writes, outputs stay 0.
- Saw: ch0 FTW=0x0100, CTRL=0b101, `ena`=1 → the ch0 lane steps 0x00, 0x01, … 0xFF, 0x00, and `wrap[0]` pulses once every 256 cycles.
- Square: ch1 FTW=0x0100, DUTY=0x40, CTRL=0b100 → 64 cycles at 0xFF, then 192 cycles at 0x00, repeating; with saw on ch0 and the lanes summed, `mix_out` equals saw+square one cycle later (max 0x1FE).
- Triangle: ch0 CTRL=0b110, FTW=0x0100 → the sample reaches 0xFE at p=0x7F, 0xFF at p=0x80, and 0x01 at p=0xFF.
- Phase reset and hold:
  - A phase reset on ch0 at p=0x37 makes the next sample 0x00, with no wrap.
  - Holding `ena`=0 for 10 cycles freezes the outputs.
  - Resuming continues from the frozen phase.
- Noise (`WAVE_NOISE_EN`): ch0 CTRL=0b111, FTW=0x8000 → after the first wrap the lane reads 0xC3 (LFSR=0x59C3). Without the macro, the lane stays 0x00 and `wrap` still pulses every 2 cycles.

Source files
------------

// File: rtl/wave_gen_multi.sv
// Multi-channel DDS waveform generator: per-channel phase accumulator with square/saw/
// triangle/noise shaping and a registered mix of all lanes. Define WAVE_NOISE_EN for the LFSR noise mode.
module wave_gen_multi #(
   parameter int CHANNELS = 2,
   parameter int ACC_W    = 16,
   parameter int DATA_W   = 8,
   parameter int CH_W     = $clog2(CHANNELS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ena,
   input  logic                       wr_en,
   input  logic [CH_W-1:0]            wr_ch,
   input  logic [1:0]                 wr_sel,
   input  logic [ACC_W-1:0]           wr_data,
   output logic [CHANNELS*DATA_W-1:0] wave_out,
   output logic [CHANNELS-1:0]        wrap,
   output logic [DATA_W+CH_W-1:0]     mix_out
);

   logic [ACC_W-1:0]       acc     [CHANNELS];
   logic [ACC_W-1:0]       ftw     [CHANNELS];
   logic [1:0]             mode    [CHANNELS];
   logic [DATA_W-1:0]      duty    [CHANNELS];
   logic [CHANNELS-1:0]    ch_en;
   logic [ACC_W-1:0]       acc_sum [CHANNELS];
   logic [CHANNELS-1:0]    carry;
   logic [CHANNELS-1:0]    wr_hit;
   logic [CHANNELS-1:0]    phase_rst;
   logic [DATA_W-1:0]      phase   [CHANNELS];
   logic [DATA_W-1:0]      tri_t   [CHANNELS];
   logic [DATA_W-1:0]      sample  [CHANNELS];
   logic [DATA_W+CH_W-1:0] mix_sum;

`ifdef WAVE_NOISE_EN
   logic [15:0] lfsr [CHANNELS];

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction
`endif

   // Samples are shaped from the pre-update accumulator; the mix sums the lanes already registered.
   always_comb begin
      mix_sum = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         wr_hit[i]               = wr_en && (wr_ch == CH_W'(i));
         phase_rst[i]            = wr_hit[i] && (wr_sel == 2'd3);
         {carry[i], acc_sum[i]}  = {1'b0, acc[i]} + {1'b0, ftw[i]};
         phase[i]                = acc[i][ACC_W-1 -: DATA_W];
         tri_t[i]                = {phase[i][DATA_W-2:0], 1'b0};
         case (mode[i])
            2'd0:    sample[i] = (phase[i] < duty[i]) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            2'd1:    sample[i] = phase[i];
            2'd2:    sample[i] = phase[i][DATA_W-1] ? ~tri_t[i] : tri_t[i];
`ifdef WAVE_NOISE_EN
            default: sample[i] = lfsr[i][DATA_W-1:0];
`else
            default: sample[i] = '0;
`endif
         endcase
         mix_sum = mix_sum + (DATA_W+CH_W)'(wave_out[i*DATA_W +: DATA_W]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            acc[i]  <= '0;
            ftw[i]  <= '0;
            mode[i] <= '0;
            duty[i] <= {1'b1, {(DATA_W-1){1'b0}}};
`ifdef WAVE_NOISE_EN
            lfsr[i] <= 16'hACE1;
`endif
         end
         ch_en    <= '0;
         wave_out <= '0;
         wrap     <= '0;
         mix_out  <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            // A phase reset beats the increment and suppresses that cycle's wrap.
            if (phase_rst[i]) begin
               acc[i]  <= '0;
               wrap[i] <= 1'b0;
            end else if (ena && ch_en[i]) begin
               acc[i]  <= acc_sum[i];
               wrap[i] <= carry[i];
`ifdef WAVE_NOISE_EN
               if (carry[i]) lfsr[i] <= lfsr_step(lfsr[i]);
`endif
            end else begin
               wrap[i] <= 1'b0;
            end
            if (ena) wave_out[i*DATA_W +: DATA_W] <= ch_en[i] ? sample[i] : '0;
            if (wr_hit[i]) begin
               case (wr_sel)
                  2'd0: ftw[i] <= wr_data;
                  2'd1: begin
                     mode[i]  <= wr_data[1:0];
                     ch_en[i] <= wr_data[2];
                  end
                  2'd2: duty[i] <= wr_data[DATA_W-1:0];
                  default: ;
               endcase
            end
         end
         if (ena) mix_out <= mix_sum;
      end
   end

endmodule

// File: tb/tb_wave_gen_multi.sv
// Bench for wave_gen_multi: directed scenarios plus random register traffic, every cycle checked against a spec-level model.
module tb_wave_gen_multi;
  localparam int CHANNELS = 2;
  localparam int ACC_W    = 16;
  localparam int DATA_W   = 8;
  localparam int CH_W     = 1;
`ifdef WAVE_NOISE_EN
  localparam bit NOISE_ON = 1'b1;
`else
  localparam bit NOISE_ON = 1'b0;
`endif

  logic                       clk;
  logic                       rst_n;
  logic                       ena;
  logic                       wr_en;
  logic [CH_W-1:0]            wr_ch;
  logic [1:0]                 wr_sel;
  logic [ACC_W-1:0]           wr_data;
  logic [CHANNELS*DATA_W-1:0] wave_out;
  logic [CHANNELS-1:0]        wrap;
  logic [DATA_W+CH_W-1:0]     mix_out;

  int tests = 0;
  int fails = 0;

  // reference model state (plain integers)
  int m_acc  [CHANNELS];
  int m_ftw  [CHANNELS];
  int m_mode [CHANNELS];
  int m_en   [CHANNELS];
  int m_duty [CHANNELS];
  int m_lfsr [CHANNELS];
  int e_wave [CHANNELS];
  int e_wrap [CHANNELS];
  int e_mix;

  wave_gen_multi #(.CHANNELS(CHANNELS), .ACC_W(ACC_W), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel),
    .wr_data(wr_data), .wave_out(wave_out), .wrap(wrap), .mix_out(mix_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_acc[c] = 0; m_ftw[c] = 0; m_mode[c] = 0; m_en[c] = 0;
      m_duty[c] = 128; m_lfsr[c] = 'hACE1; e_wave[c] = 0; e_wrap[c] = 0;
    end
    e_mix = 0;
  endtask

  function automatic int shape(int c);
    int p, t;
    p = m_acc[c] / 256;
    t = (2 * p) % 256;
    case (m_mode[c])
      0: return (p < m_duty[c]) ? 255 : 0;
      1: return p;
      2: return (p >= 128) ? 255 - t : t;
      default: return NOISE_ON ? (m_lfsr[c] % 256) : 0;
    endcase
  endfunction

  task automatic model_edge(input bit en_i, input bit we, input int ch, input int sel, input int data);
    int s [CHANNELS];
    int nmix, sum, fb;
    nmix = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      s[c] = shape(c);
      nmix += e_wave[c];
    end
    for (int c = 0; c < CHANNELS; c++) begin
      if (en_i) e_wave[c] = m_en[c] ? s[c] : 0;
      if (we && ch == c && sel == 3) begin
        m_acc[c] = 0;
        e_wrap[c] = 0;
      end else if (en_i && m_en[c] != 0) begin
        sum = m_acc[c] + m_ftw[c];
        e_wrap[c] = (sum > 65535) ? 1 : 0;
        m_acc[c] = sum % 65536;
        if (e_wrap[c] != 0) begin
          fb = ((m_lfsr[c] >> 15) ^ (m_lfsr[c] >> 13) ^ (m_lfsr[c] >> 12) ^ (m_lfsr[c] >> 10)) & 1;
          m_lfsr[c] = ((m_lfsr[c] * 2) % 65536) + fb;
        end
      end else begin
        e_wrap[c] = 0;
      end
      if (we && ch == c) begin
        case (sel)
          0: m_ftw[c] = data % 65536;
          1: begin m_mode[c] = data % 4; m_en[c] = (data >> 2) & 1; end
          2: m_duty[c] = data % 256;
          default: ;
        endcase
      end
    end
    if (en_i) e_mix = nmix;
  endtask

  task automatic check_all();
    for (int c = 0; c < CHANNELS; c++) begin
      check($sformatf("wave_ch%0d", c), 32'(wave_out[c*DATA_W +: DATA_W]), 32'(e_wave[c]));
      check($sformatf("wrap_ch%0d", c), 32'(wrap[c]), 32'(e_wrap[c]));
    end
    check("mix", 32'(mix_out), 32'(e_mix));
  endtask

  // driver: drive inputs, take one edge, advance the model, compare
  task automatic cyc(input bit en_i, input bit we, input int ch, input int sel, input int data);
    ena = en_i; wr_en = we; wr_ch = CH_W'(ch); wr_sel = 2'(sel); wr_data = ACC_W'(data);
    @(posedge clk);
    model_edge(en_i, we, ch, sel, data);
    #1;
    check_all();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; ena = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int n_wrap, n_ff, n_fe, n_01, found;
    bit e, w;
    int ch, sel, d;
    rst_n = 1'b1; ena = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0;
    #3;
    do_reset();
    for (int n = 0; n < 5; n++) cyc(1, 0, 0, 0, 0);

    // saw on ch0
    cyc(1, 1, 0, 0, 'h0100);
    cyc(1, 1, 0, 1, 'b101);
    n_wrap = 0; n_ff = 0;
    for (int n = 0; n < 512; n++) begin
      cyc(1, 0, 0, 0, 0);
      n_wrap += int'(wrap[0]);
      n_ff += (wave_out[7:0] == 8'hFF) ? 1 : 0;
    end
    check("saw_wrap_count", 32'(n_wrap), 2);
    check("saw_ff_count", 32'(n_ff), 2);

    // square on ch1, mixed with saw
    cyc(1, 1, 1, 0, 'h0100);
    cyc(1, 1, 1, 2, 'h40);
    cyc(1, 1, 1, 1, 'b100);
    n_ff = 0;
    for (int n = 0; n < 256; n++) begin
      cyc(1, 0, 0, 0, 0);
      n_ff += (wave_out[15:8] == 8'hFF) ? 1 : 0;
    end
    check("square_high_count", 32'(n_ff), 64);

    // triangle on ch0 (first lane after the write still uses saw)
    cyc(1, 1, 0, 1, 'b110);
    cyc(1, 0, 0, 0, 0);
    n_ff = 0; n_fe = 0; n_01 = 0;
    for (int n = 0; n < 256; n++) begin
      cyc(1, 0, 0, 0, 0);
      n_ff += (wave_out[7:0] == 8'hFF) ? 1 : 0;
      n_fe += (wave_out[7:0] == 8'hFE) ? 1 : 0;
      n_01 += (wave_out[7:0] == 8'h01) ? 1 : 0;
    end
    check("tri_ff_count", 32'(n_ff), 1);
    check("tri_fe_count", 32'(n_fe), 1);
    check("tri_01_count", 32'(n_01), 1);

    // phase reset at p=0x37
    found = 0;
    for (int n = 0; n < 300 && found == 0; n++) begin
      if (m_acc[0] == 'h3700) found = 1;
      else cyc(1, 0, 0, 0, 0);
    end
    check("p37_reached", 32'(found), 1);
    cyc(1, 1, 0, 3, 'h1234);
    check("prst_no_wrap", 32'(wrap[0]), 0);
    cyc(1, 0, 0, 0, 0);
    check("prst_sample", 32'(wave_out[7:0]), 0);

    // hold with ena=0 (a write still lands), then resume
    for (int n = 0; n < 10; n++) cyc(0, (n == 4), 1, 2, 'h80);
    for (int n = 0; n < 20; n++) cyc(1, 0, 0, 0, 0);

    // random register traffic
    for (int n = 0; n < 1500; n++) begin
      e = ($urandom_range(0, 9) != 0);
      w = ($urandom_range(0, 3) == 0);
      ch = $urandom_range(0, 1);
      sel = $urandom_range(0, 3);
      case (sel)
        0: d = $urandom_range(0, 65535);
        1: d = $urandom_range(0, 7) | (($urandom_range(0, 3) != 0) ? 4 : 0);
        2: d = $urandom_range(0, 255);
        default: d = $urandom_range(0, 65535);
      endcase
      cyc(e, w, ch, sel, d);
    end

    // noise on ch0
    do_reset();
    cyc(1, 1, 0, 0, 'h8000);
    cyc(1, 1, 0, 1, 'b111);
    found = 0;
    for (int n = 0; n < 10 && found == 0; n++) begin
      cyc(1, 0, 0, 0, 0);
      if (wrap[0] == 1'b1) found = 1;
    end
    check("noise_first_wrap", 32'(found), 1);
    cyc(1, 0, 0, 0, 0);
    check("noise_lane", 32'(wave_out[7:0]), NOISE_ON ? 32'hC3 : 32'h0);
    n_wrap = 0;
    for (int n = 0; n < 8; n++) begin
      cyc(1, 0, 0, 0, 0);
      n_wrap += int'(wrap[0]);
    end
    check("noise_wrap_count", 32'(n_wrap), 4);

    // mid-run asynchronous reset, then idle
    for (int n = 0; n < 5; n++) cyc(1, 0, 0, 0, 0);
    do_reset();
    for (int n = 0; n < 5; n++) cyc(1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
